// File: rtl/regfile_access_arbiter_if.sv
// Client port bundle for regfile_access_arbiter.
//
// One instance per client. Carries a request channel (valid/ready) and a
// response channel (valid/ready).
//   req_valid/req_ready/req_write/req_regnum/req_wdata : request from client
//   rsp_valid/rsp_rdata/rsp_ready                      : response to client
//
// Handshake rule (both channels): a transfer happens at the rising clock edge
// where valid and ready are both 1. The sender holds valid and its payload
// stable until that edge. ready may depend combinationally on valid.
//
// Modports:
//   master : the client side (drives request, accepts response)
//   slave  : the arbiter side
interface regfile_access_arbiter_if #(
  parameter int DATA_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [3:0]        req_regnum;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_ready;

  modport master (
    output req_valid, req_write, req_regnum, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_regnum, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Arbiter sharing the read port and write port of a 16x16 register file
// between a core client (c0) and a debug client (c1), plus a clear sequencer
// that zero-writes all 16 registers after reset or on command.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   c0, c1           : client bundles (slave modport), request + response
//   clear_start      : pulse in SERVE to start a clear sequence
//   busy             : clear sequence in progress
//   rf_rd_regnum     : register file read select (MSB always 0)
//   rf_rd_data       : register file read data (combinational)
//   rf_wr_regnum     : register file write address (MSB always 0)
//   rf_wr_data       : register file write data
//   rf_write_enable  : register file write strobe
//   dbg_state        : current FSM state (0 = CLEAR, 1 = SERVE)
module regfile_access_arbiter #(
  parameter int DATA_W         = 16,
  parameter int REG_W          = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_access_arbiter_if.slave  c0,
  regfile_access_arbiter_if.slave  c1,
  input  logic                     clear_start,
  output logic                     busy,
  output logic [REG_W-1:0]         rf_rd_regnum,
  input  logic [DATA_W-1:0]        rf_rd_data,
  output logic [REG_W-1:0]         rf_wr_regnum,
  output logic [DATA_W-1:0]        rf_wr_data,
  output logic                     rf_write_enable,
  output logic [0:0]               dbg_state
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_SERVE;

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rr_last_c1_q, rr_last_c1_d;
  logic              rsp_valid0_q, rsp_valid0_d;
  logic              rsp_valid1_q, rsp_valid1_d;
  logic [DATA_W-1:0] rsp_rdata0_q, rsp_rdata0_d;
  logic [DATA_W-1:0] rsp_rdata1_q, rsp_rdata1_d;

  logic              serve;
  logic              elig0, elig1;
  logic              grant0, grant1, grant_any;
  logic              gnt_write;
  logic [3:0]        gnt_regnum;
  logic [DATA_W-1:0] gnt_wdata;

  // Arbitration. A client with an undelivered response is not eligible, so a
  // lone client is granted at most every other cycle. On a tie the client
  // not granted last wins.
  always_comb begin
    serve      = (state_q == ST_SERVE);
    elig0      = c0.req_valid & ~rsp_valid0_q;
    elig1      = c1.req_valid & ~rsp_valid1_q;
    grant0     = ~reset & serve & elig0 & (~elig1 | rr_last_c1_q);
    grant1     = ~reset & serve & elig1 & (~elig0 | ~rr_last_c1_q);
    grant_any  = grant0 | grant1;
    gnt_write  = grant1 ? c1.req_write  : c0.req_write;
    gnt_regnum = grant1 ? c1.req_regnum : c0.req_regnum;
    gnt_wdata  = grant1 ? c1.req_wdata  : c0.req_wdata;
  end

  assign c0.req_ready = grant0;
  assign c1.req_ready = grant1;
  assign c0.rsp_valid = rsp_valid0_q;
  assign c1.rsp_valid = rsp_valid1_q;
  assign c0.rsp_rdata = rsp_rdata0_q;
  assign c1.rsp_rdata = rsp_rdata1_q;
  assign busy         = ~serve;
  assign dbg_state    = state_q;

  // Register file port drive. CLEAR owns the write port; in SERVE the ports
  // follow the granted request and idle at zero otherwise.
  always_comb begin
    rf_rd_regnum    = '0;
    rf_wr_regnum    = '0;
    rf_wr_data      = '0;
    rf_write_enable = 1'b0;
    if (!serve) begin
      rf_write_enable = ~reset;
      rf_wr_regnum    = REG_W'(cnt_q);
    end else if (grant_any) begin
      rf_rd_regnum = REG_W'(gnt_regnum);
      if (gnt_write) begin
        rf_write_enable = 1'b1;
        rf_wr_regnum    = REG_W'(gnt_regnum);
        rf_wr_data      = gnt_wdata;
      end
    end
  end

  // FSM and clear counter. The counter wraps from 15 to 0 on the same edge
  // that leaves CLEAR, so it is already 0 for the next clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_SERVE;
      end
      default: begin
        cnt_d = 4'd0;
        if (clear_start) state_d = ST_CLEAR;
      end
    endcase
  end

  // Round-robin pointer moves only on a grant.
  always_comb begin
    rr_last_c1_d = rr_last_c1_q;
    if (grant0) rr_last_c1_d = 1'b0;
    if (grant1) rr_last_c1_d = 1'b1;
  end

  // Response registers. A write echoes its data; a read captures the
  // register file output at the grant edge.
  always_comb begin
    rsp_valid0_d = rsp_valid0_q;
    rsp_rdata0_d = rsp_rdata0_q;
    if (grant0) begin
      rsp_valid0_d = 1'b1;
      rsp_rdata0_d = c0.req_write ? c0.req_wdata : rf_rd_data;
    end else if (rsp_valid0_q && c0.rsp_ready) begin
      rsp_valid0_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid1_d = rsp_valid1_q;
    rsp_rdata1_d = rsp_rdata1_q;
    if (grant1) begin
      rsp_valid1_d = 1'b1;
      rsp_rdata1_d = c1.req_write ? c1.req_wdata : rf_rd_data;
    end else if (rsp_valid1_q && c1.rsp_ready) begin
      rsp_valid1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      cnt_q        <= 4'd0;
      rr_last_c1_q <= 1'b1;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_rdata0_q <= '0;
      rsp_rdata1_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_last_c1_q <= rr_last_c1_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_rdata0_q <= rsp_rdata0_d;
      rsp_rdata1_q <= rsp_rdata1_d;
    end
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
module tb_regfile_access_arbiter;
  localparam int DW = 16;
  localparam int RW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT + register file model ----------------
  regfile_access_arbiter_if #(.DATA_W(DW)) c0_if ();
  regfile_access_arbiter_if #(.DATA_W(DW)) c1_if ();

  logic          clear_start;
  logic          busy;
  logic [RW-1:0] rf_rd_regnum;
  logic [DW-1:0] rf_rd_data;
  logic [RW-1:0] rf_wr_regnum;
  logic [DW-1:0] rf_wr_data;
  logic          rf_write_enable;
  logic [0:0]    dbg_state;

  regfile_access_arbiter #(.DATA_W(DW), .REG_W(RW), .CLEAR_ON_RESET(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .c0              (c0_if),
    .c1              (c1_if),
    .clear_start     (clear_start),
    .busy            (busy),
    .rf_rd_regnum    (rf_rd_regnum),
    .rf_rd_data      (rf_rd_data),
    .rf_wr_regnum    (rf_wr_regnum),
    .rf_wr_data      (rf_wr_data),
    .rf_write_enable (rf_write_enable),
    .dbg_state       (dbg_state)
  );

  logic [DW-1:0] rf_mem [16];
  initial for (int i = 0; i < 16; i++) rf_mem[i] = 16'hA5A0 + 16'(i);
  always @(posedge clk) if (rf_write_enable) rf_mem[rf_wr_regnum[3:0]] <= rf_wr_data;
  assign rf_rd_data = rf_mem[rf_rd_regnum[3:0]];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int gnt_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input int c, input logic [DW-1:0] act);
    logic [DW-1:0] e;
    if (c == 0 && exp_q0.size() == 0 || c == 1 && exp_q1.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL c%0d_rsp_unexpected: got response %h expected none (cycle %0d)", c, act, cyc);
    end else begin
      e = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("c%0d_rsp_rdata", c), 32'(act), 32'(e));
    end
  endtask

  // Monitor: compare every accepted response against the expected queue.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (c0_if.rsp_valid === 1'b1 && c0_if.rsp_ready === 1'b1) pop_check(0, c0_if.rsp_rdata);
      if (c1_if.rsp_valid === 1'b1 && c1_if.rsp_ready === 1'b1) pop_check(1, c1_if.rsp_rdata);
    end
  end

  // Grant log for ordering checks.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (c0_if.req_ready === 1'b1) gnt_q.push_back(0);
      if (c1_if.req_ready === 1'b1) gnt_q.push_back(1);
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge. Holds the request until granted (bounded),
  // pushes the expected response, and returns at the next falling edge.
  task automatic drive(input int c, input logic wr, input logic [3:0] rn,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp,
                       output int gcyc);
    bit got;
    logic rdy;
    got  = 0;
    gcyc = -1;
    if (c == 0) begin
      c0_if.req_valid = 1'b1; c0_if.req_write = wr; c0_if.req_regnum = rn; c0_if.req_wdata = wd;
    end else begin
      c1_if.req_valid = 1'b1; c1_if.req_write = wr; c1_if.req_regnum = rn; c1_if.req_wdata = wd;
    end
    for (int k = 0; k < 200 && !got; k++) begin
      #1;
      rdy = (c == 0) ? c0_if.req_ready : c1_if.req_ready;
      if (rdy === 1'b1) begin
        got  = 1;
        gcyc = cyc;
        if (c == 0) exp_q0.push_back(exp);
        else        exp_q1.push_back(exp);
      end
      @(negedge clk);
    end
    if (c == 0) c0_if.req_valid = 1'b0;
    else        c1_if.req_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: client %0d got no grant, expected one within 200 cycles", c);
    end
  endtask

  // Called at a falling edge during a clear: 16 write cycles at regnum 0..15.
  task automatic check_clear();
    for (int i = 0; i < 16; i++) begin
      #1;
      check("clr_busy",      32'(busy), 32'd1);
      check("clr_we",        32'(rf_write_enable), 32'd1);
      check("clr_wr_regnum", 32'(rf_wr_regnum), 32'(i));
      check("clr_wr_data",   32'(rf_wr_data), 32'd0);
      check("clr_c0_ready",  32'(c0_if.req_ready), 32'd0);
      check("clr_c1_ready",  32'(c1_if.req_ready), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    summary();
    $finish;
  end

  // ---------------- stimulus ----------------
  int k0, g0, g1, s, acc, b0, b1, kk;
  int ga[3];

  initial begin
    reset = 1'b1;
    clear_start = 1'b0;
    c0_if.req_valid = 1'b0; c0_if.req_write = 1'b0; c0_if.req_regnum = 4'd0; c0_if.req_wdata = '0;
    c1_if.req_valid = 1'b0; c1_if.req_write = 1'b0; c1_if.req_regnum = 4'd0; c1_if.req_wdata = '0;
    c0_if.rsp_ready = 1'b1;
    c1_if.rsp_ready = 1'b1;

    // Reset state, both clients requesting.
    repeat (3) @(negedge clk);
    c0_if.req_valid = 1'b1;
    c1_if.req_valid = 1'b1;
    #1;
    check("rst_c0_ready",     32'(c0_if.req_ready), 32'd0);
    check("rst_c1_ready",     32'(c1_if.req_ready), 32'd0);
    check("rst_we",           32'(rf_write_enable), 32'd0);
    check("rst_c0_rsp_valid", 32'(c0_if.rsp_valid), 32'd0);
    check("rst_c1_rsp_valid", 32'(c1_if.rsp_valid), 32'd0);
    check("rst_c0_rsp_rdata", 32'(c0_if.rsp_rdata), 32'd0);
    check("rst_c1_rsp_rdata", 32'(c1_if.rsp_rdata), 32'd0);
    @(negedge clk);

    // Clear on leaving reset; c0 wins the first tie on the first SERVE cycle.
    reset = 1'b0;
    k0 = cyc;
    fork
      drive(0, 1'b0, 4'd5, 16'h0, 16'h0000, g0);
      drive(1, 1'b0, 4'd6, 16'h0, 16'h0000, g1);
      check_clear();
    join
    check("first_grant_c0", 32'(g0), 32'(k0 + 16));
    check("next_grant_c1",  32'(g1), 32'(k0 + 17));

    // Write then read R3 from c0.
    drive(0, 1'b1, 4'd3, 16'hBEEF, 16'hBEEF, g0);
    drive(0, 1'b0, 4'd3, 16'h0,    16'hBEEF, g0);
    #1;
    check("rd_latency_valid", 32'(c0_if.rsp_valid), 32'd1);
    check("rd_latency_rdata", 32'(c0_if.rsp_rdata), 32'hBEEF);
    @(negedge clk);

    // Preload R1 from c0, R2 from c1 (last grant = c1).
    drive(0, 1'b1, 4'd1, 16'h0011, 16'h0011, g0);
    drive(1, 1'b1, 4'd2, 16'h0022, 16'h0022, g1);

    // Continuous reads from both: grants alternate starting with c0.
    gnt_q.delete();
    fork
      begin for (int i = 0; i < 4; i++) drive(0, 1'b0, 4'd1, 16'h0, 16'h0011, g0); end
      begin for (int i = 0; i < 4; i++) drive(1, 1'b0, 4'd2, 16'h0, 16'h0022, g1); end
    join
    check("alt_count", 32'(gnt_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < gnt_q.size(); i++) check("alt_order", 32'(gnt_q[i]), 32'(i % 2));
    @(negedge clk);

    // c1 back-pressures its response for 5 cycles.
    c1_if.rsp_ready = 1'b0;
    fork
      begin for (int i = 0; i < 3; i++) drive(0, 1'b0, 4'd1, 16'h0, 16'h0011, ga[i]); end
      begin
        drive(1, 1'b0, 4'd2, 16'h0, 16'h0022, b0);
        drive(1, 1'b0, 4'd2, 16'h0, 16'h0022, b1);
      end
      begin
        kk = 0;
        #1;
        while (c1_if.rsp_valid !== 1'b1 && kk < 20) begin @(negedge clk); #1; kk++; end
        check("hold_seen", 32'(c1_if.rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
          check("hold_valid",     32'(c1_if.rsp_valid), 32'd1);
          check("hold_rdata",     32'(c1_if.rsp_rdata), 32'h0022);
          check("hold_req_ready", 32'(c1_if.req_ready), 32'd0);
          @(negedge clk);
          #1;
        end
        c1_if.rsp_ready = 1'b1;
        acc = cyc;
      end
    join
    check("bp_c1_after_c0", 32'(b0), 32'(ga[0] + 1));
    check("bp_c0_spacing1", 32'(ga[1] - ga[0]), 32'd2);
    check("bp_c0_spacing2", 32'(ga[2] - ga[1]), 32'd2);
    check("bp_c1_resume",   32'(b1), 32'(acc + 1));
    @(negedge clk);

    // Write R7, then clear_start together with a granted c0 write of R9.
    drive(0, 1'b1, 4'd7, 16'h1234, 16'h1234, g0);
    @(negedge clk);
    s = cyc;
    fork
      drive(0, 1'b1, 4'd9, 16'h5555, 16'h5555, g0);
      begin
        clear_start = 1'b1;
        #2;
        check("cs_we",        32'(rf_write_enable), 32'd1);
        check("cs_wr_regnum", 32'(rf_wr_regnum), 32'd9);
        check("cs_wr_data",   32'(rf_wr_data), 32'h5555);
        check("cs_busy",      32'(busy), 32'd0);
        @(negedge clk);
        clear_start = 1'b0;
      end
    join
    check("cs_grant_cycle", 32'(g0), 32'(s));
    check_clear();
    #1;
    check("clear_done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 4'd7, 16'h0, 16'h0000, g0);
    drive(1, 1'b0, 4'd9, 16'h0, 16'h0000, g1);
    @(negedge clk);

    // Pending c1 response, then reset in the middle of a clear (cnt = 7).
    c1_if.rsp_ready = 1'b0;
    drive(1, 1'b0, 4'd4, 16'h0, 16'h0000, g1);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    check("pre_reset_cnt7", 32'(rf_wr_regnum), 32'd7);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_we",          32'(rf_write_enable), 32'd0);
    check("reset_rsp_dropped", 32'(c1_if.rsp_valid), 32'd0);
    exp_q1.delete();
    @(negedge clk);
    reset = 1'b0;
    c1_if.rsp_ready = 1'b1;
    check_clear();

    drive(0, 1'b0, 4'd3, 16'h0, 16'h0000, g0);
    repeat (3) @(negedge clk);
    check("exp_q0_empty", 32'(exp_q0.size()), 32'd0);
    check("exp_q1_empty", 32'(exp_q1.size()), 32'd0);

    summary();
    $finish;
  end

endmodule
